// File: rtl/comparador_minmax_ctrl.sv
// Streaming min/max tracker: N unsigned 4-bit samples pass through one shared
// magnitude comparator, time-multiplexed between the stored max and the stored min.

module comparador4bit_struct (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       maior,
    output logic       menor,
    output logic       igual
);

    // Unsigned magnitude comparison of a against b
    always_comb begin
        maior = 1'b0;
        menor = 1'b0;
        igual = 1'b0;
        if (a > b) begin
            maior = 1'b1;
        end else if (a < b) begin
            menor = 1'b1;
        end else begin
            igual = 1'b1;
        end
    end

endmodule

module comparador_minmax_ctrl #(
    parameter int N = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [3:0]                        dado,
    input  logic                              dado_valido,
    output logic                              pronto,
    output logic                              ocupado,
    output logic                              fim,
    output logic [3:0]                        valor_maior,
    output logic [3:0]                        valor_menor,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_maior,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_menor
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0] LAST_IDX = (IW+1)'(N - 1);
    localparam logic [IW:0] ONE      = (IW+1)'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ESPERA  = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        FIM     = 3'd4
    } state_t;

    state_t        state_r;
    logic [IW:0]   count_r;
    logic [3:0]    reg_dado_r;
    logic [3:0]    valor_maior_r;
    logic [3:0]    valor_menor_r;
    logic [IW-1:0] idx_maior_r;
    logic [IW-1:0] idx_menor_r;
    logic          pronto_r;
    logic          ocupado_r;
    logic          fim_r;

    logic [3:0]    cmp_b_s;
    logic          maior_s;
    logic          menor_s;
    logic          igual_s;
    logic          upd_maior_s;
    logic          upd_menor_s;

    // Comparator operand b follows the phase: stored max, then stored min
    always_comb begin
        cmp_b_s = valor_maior_r;
        case (state_r)
            CMP_MAX: cmp_b_s = valor_maior_r;
            CMP_MIN: cmp_b_s = valor_menor_r;
            default: cmp_b_s = valor_maior_r;
        endcase
    end

    comparador4bit_struct u_cmp (
        .a     (reg_dado_r),
        .b     (cmp_b_s),
        .maior (maior_s),
        .menor (menor_s),
        .igual (igual_s)
    );

    // Strict comparison: a tie never moves the index off the first occurrence
    assign upd_maior_s = maior_s & ~igual_s;
    assign upd_menor_s = menor_s & ~igual_s;

    // Control FSM with registered handshake/status flags and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            count_r       <= '0;
            reg_dado_r    <= 4'd0;
            valor_maior_r <= 4'd0;
            valor_menor_r <= 4'd0;
            idx_maior_r   <= '0;
            idx_menor_r   <= '0;
            pronto_r      <= 1'b0;
            ocupado_r     <= 1'b0;
            fim_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    fim_r <= 1'b0;
                    if (start) begin
                        state_r   <= ESPERA;
                        count_r   <= '0;
                        pronto_r  <= 1'b1;
                        ocupado_r <= 1'b1;
                    end else begin
                        pronto_r  <= 1'b0;
                        ocupado_r <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (dado_valido && pronto_r) begin
                        if (count_r == '0) begin
                            valor_maior_r <= dado;
                            valor_menor_r <= dado;
                            idx_maior_r   <= '0;
                            idx_menor_r   <= '0;
                            count_r       <= ONE;
                        end else begin
                            reg_dado_r <= dado;
                            state_r    <= CMP_MAX;
                            pronto_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ESPERA;
                    end
                end
                CMP_MAX: begin
                    if (upd_maior_s) begin
                        valor_maior_r <= reg_dado_r;
                        idx_maior_r   <= count_r[IW-1:0];
                    end else begin
                        valor_maior_r <= valor_maior_r;
                    end
                    state_r <= CMP_MIN;
                end
                CMP_MIN: begin
                    if (upd_menor_s) begin
                        valor_menor_r <= reg_dado_r;
                        idx_menor_r   <= count_r[IW-1:0];
                    end else begin
                        valor_menor_r <= valor_menor_r;
                    end
                    count_r <= count_r + ONE;
                    if (count_r == LAST_IDX) begin
                        state_r <= FIM;
                        fim_r   <= 1'b1;
                    end else begin
                        state_r  <= ESPERA;
                        pronto_r <= 1'b1;
                    end
                end
                FIM: begin
                    state_r   <= IDLE;
                    fim_r     <= 1'b0;
                    ocupado_r <= 1'b0;
                    pronto_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    pronto_r  <= 1'b0;
                    ocupado_r <= 1'b0;
                    fim_r     <= 1'b0;
                end
            endcase
        end
    end

    assign pronto      = pronto_r;
    assign ocupado     = ocupado_r;
    assign fim         = fim_r;
    assign valor_maior = valor_maior_r;
    assign valor_menor = valor_menor_r;
    assign idx_maior   = idx_maior_r;
    assign idx_menor   = idx_menor_r;

endmodule

// File: tb/tb_comparador_minmax_ctrl.sv
// Directed bench for comparador_minmax_ctrl with N=8: results, handshake timing,
// tie handling, ignored start/valid, and asynchronous reset mid-run.

module tb_comparador_minmax_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    dado = 4'd0;
    logic          dado_valido = 1'b0;
    logic          pronto;
    logic          ocupado;
    logic          fim;
    logic [3:0]    valor_maior;
    logic [3:0]    valor_menor;
    logic [IW-1:0] idx_maior;
    logic [IW-1:0] idx_menor;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_cyc = 0;
    logic [3:0] seq [8];

    comparador_minmax_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dado        (dado),
        .dado_valido (dado_valido),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .fim         (fim),
        .valor_maior (valor_maior),
        .valor_menor (valor_menor),
        .idx_maior   (idx_maior),
        .idx_menor   (idx_menor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        int n = 0;
        dado = v;
        dado_valido = 1'b1;
        while (pronto !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("send_pronto", {7'd0, pronto}, 8'd1);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fim(input string tag);
        int n = 0;
        while (fim !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_fim"}, {7'd0, fim}, 8'd1);
        tick();
        check({tag, "_fim_pulse"}, {7'd0, fim}, 8'd0);
        check({tag, "_idle"}, {7'd0, ocupado}, 8'd0);
    endtask

    task automatic check_res(input string tag, input logic [3:0] mx, input logic [2:0] imx,
                             input logic [3:0] mn, input logic [2:0] imn);
        check({tag, "_max"},  {4'd0, valor_maior}, {4'd0, mx});
        check({tag, "_imax"}, {5'd0, idx_maior},   {5'd0, imx});
        check({tag, "_min"},  {4'd0, valor_menor}, {4'd0, mn});
        check({tag, "_imin"}, {5'd0, idx_menor},   {5'd0, imn});
    endtask

    task automatic run_seq(input string tag);
        start_run();
        for (int i = 0; i < 8; i++) send(seq[i]);
        dado_valido = 1'b0;
        wait_fim(tag);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_pronto", {7'd0, pronto}, 8'd0);
        check("rst_ocupado", {7'd0, ocupado}, 8'd0);
        check("rst_fim", {7'd0, fim}, 8'd0);
        check_res("rst", 4'd0, 3'd0, 4'd0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("idle_ocupado", {7'd0, ocupado}, 8'd0);
        check("idle_pronto", {7'd0, pronto}, 8'd0);

        // mixed run with pronto pattern and fim latency
        start_run();
        check("mix_ocupado", {7'd0, ocupado}, 8'd1);
        check("mix_pronto0", {7'd0, pronto}, 8'd1);
        seq = '{4'd5, 4'd3, 4'd12, 4'd0, 4'd15, 4'd7, 4'd15, 4'd0};
        for (int i = 0; i < 8; i++) begin
            send(seq[i]);
            if (i == 0) begin
                check("mix_first_pronto", {7'd0, pronto}, 8'd1);
                check("mix_first_max", {4'd0, valor_maior}, 8'd5);
            end else begin
                check("mix_gap", 8'(acc_cyc - prev_cyc), (i == 1) ? 8'd1 : 8'd3);
                check("mix_cmp_pronto", {7'd0, pronto}, 8'd0);
            end
            prev_cyc = acc_cyc;
        end
        dado_valido = 1'b0;
        check("mix_lat1", {7'd0, fim}, 8'd0);
        tick();
        check("mix_lat2", {7'd0, fim}, 8'd0);
        tick();
        check("mix_lat3", {7'd0, fim}, 8'd1);
        tick();
        check("mix_lat4", {7'd0, fim}, 8'd0);
        check("mix_done", {7'd0, ocupado}, 8'd0);
        check_res("mix", 4'd15, 3'd4, 4'd0, 3'd3);

        // all equal
        seq = '{4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10};
        run_seq("eq");
        check_res("eq", 4'd10, 3'd0, 4'd10, 3'd0);

        // descending and ascending
        seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        run_seq("desc");
        check_res("desc", 4'd15, 3'd0, 4'd8, 3'd7);
        seq = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        run_seq("asc");
        check_res("asc", 4'd15, 3'd7, 4'd8, 3'd0);

        // handshake abuse: valid with dado=1 during CMP_*, idle gaps in ESPERA
        seq = '{4'd6, 4'd9, 4'd2, 4'd13, 4'd4, 4'd11, 4'd3, 4'd8};
        start_run();
        for (int i = 0; i < 8; i++) begin
            dado = 4'd1;
            dado_valido = 1'b0;
            tick();
            tick();
            send(seq[i]);
            if (i > 0) begin
                dado = 4'd1;
                dado_valido = 1'b1;
                tick();
                tick();
            end
        end
        dado_valido = 1'b0;
        check("abuse_fim", {7'd0, fim}, 8'd1);
        tick();
        check("abuse_fim_pulse", {7'd0, fim}, 8'd0);
        check_res("abuse", 4'd13, 3'd3, 4'd2, 3'd2);

        // start held high through ESPERA, CMP_* and FIM
        seq = '{4'd4, 4'd10, 4'd1, 4'd6, 4'd8, 4'd2, 4'd10, 4'd1};
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(seq[i]);
        dado_valido = 1'b0;
        tick();
        tick();
        check("hold_fim", {7'd0, fim}, 8'd1);
        tick();
        check("hold_idle", {7'd0, ocupado}, 8'd0);
        check_res("hold", 4'd10, 3'd1, 4'd1, 3'd2);
        tick();
        check("rearm_ocupado", {7'd0, ocupado}, 8'd1);
        check("rearm_hold_max", {4'd0, valor_maior}, 8'd10);
        start = 1'b0;
        send(4'd3);
        check_res("rearm_first", 4'd3, 3'd0, 4'd3, 3'd0);

        // asynchronous reset in CMP_MAX after 3 samples
        send(4'd7);
        send(4'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pronto", {7'd0, pronto}, 8'd0);
        check("arst_ocupado", {7'd0, ocupado}, 8'd0);
        check("arst_fim", {7'd0, fim}, 8'd0);
        check_res("arst", 4'd0, 3'd0, 4'd0, 3'd0);
        dado_valido = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst_idle", {7'd0, ocupado}, 8'd0);
        seq = '{4'd9, 4'd11, 4'd3, 4'd14, 4'd3, 4'd14, 4'd5, 4'd6};
        run_seq("fresh");
        check_res("fresh", 4'd14, 3'd3, 4'd3, 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
